// File: rtl/count_readout_pkg.sv
// Shared constants, state type and frame byte selection for the count readout block.
package count_readout_pkg;

    localparam logic [7:0] HDR_BASE  = 8'hA4;
    localparam int         FRAME_LEN = 6;
    localparam int         IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte sel of the frame built from a snapshot; the last byte is the XOR check.
    function automatic logic [7:0] frame_byte(
        input logic [31:0]      word,
        input logic             dir,
        input logic [IDX_W-1:0] sel
    );
        logic [7:0] hdr;
        hdr = HDR_BASE | {7'd0, dir};
        case (sel)
            IDX_W'(0): frame_byte = hdr;
            IDX_W'(1): frame_byte = word[31:24];
            IDX_W'(2): frame_byte = word[23:16];
            IDX_W'(3): frame_byte = word[15:8];
            IDX_W'(4): frame_byte = word[7:0];
            IDX_W'(5): frame_byte = hdr ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
            default:   frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/count_readout_period_tick.sv
// Free-running period counter that emits a one-cycle tick every PERIOD cycles while enabled.
module period_tick
    import count_readout_pkg::*;
#(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic auto_en,
    output logic tick
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!auto_en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = auto_en && (cnt == LAST);

endmodule

// File: rtl/count_readout.sv
// Snapshots count3/direction on a trigger and streams it as a 6-byte valid/ready frame.
// state | meaning
// IDLE  | no frame in flight, tx_valid low
// SEND  | presenting snapshot byte idx, tx_valid high
module count_readout
    import count_readout_pkg::*;
#(
    parameter int PERIOD = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        direction,
    input  logic [31:0] count3,
    input  logic        snap_req,
    input  logic        auto_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  drop_cnt
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      snap_word;
    logic             snap_dir;
    logic             tick;
    logic             trig;
    logic             last_xfer;
    logic             accept;
    logic             drop;

    period_tick #(.PERIOD(PERIOD)) u_period_tick (
        .clk     (clk),
        .reset   (reset),
        .auto_en (auto_en),
        .tick    (tick)
    );

    assign trig      = snap_req | tick;
    assign last_xfer = (state == SEND) && tx_ready && (idx == IDX_W'(FRAME_LEN - 1));
    // The slot freed by the final byte transfer can be reused on the same edge.
    assign accept    = trig && ((state == IDLE) || last_xfer);
    assign drop      = trig && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            snap_word <= '0;
            snap_dir  <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            overrun <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (accept) begin
                state     <= SEND;
                busy      <= 1'b1;
                idx       <= '0;
                snap_word <= count3;
                snap_dir  <= direction;
                tx_valid  <= 1'b1;
                tx_data   <= frame_byte(count3, direction, IDX_W'(0));
            end else if (last_xfer) begin
                state    <= IDLE;
                busy     <= 1'b0;
                idx      <= '0;
                tx_valid <= 1'b0;
            end else if ((state == SEND) && tx_ready) begin
                idx     <= idx + IDX_W'(1);
                tx_data <= frame_byte(snap_word, snap_dir, idx + IDX_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_count_readout.sv
// Randomized and scripted checks of count_readout against a frame-level reference model.
module tb_count_readout;

    localparam int PER8 = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        direction = 1'b0;
    logic [31:0] count3 = '0;
    logic        snap_req = 1'b0;
    logic        auto_en = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data, tx_data4;
    logic        tx_valid, tx_valid4;
    logic        busy, busy4;
    logic        overrun, overrun4;
    logic [7:0]  drop_cnt, drop_cnt4;

    int passed = 0;
    int total  = 0;

    // Reference model: a frame being sent, its position, and the drop tally.
    int         m_per;
    bit         m_busy;
    int         m_pos;
    bit         m_ovr;
    int         m_drops;
    logic [7:0] m_frame [6];

    count_readout #(.PERIOD(PER8)) dut (
        .clk(clk), .reset(reset), .direction(direction), .count3(count3),
        .snap_req(snap_req), .auto_en(auto_en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    count_readout #(.PERIOD(4)) dut4 (
        .clk(clk), .reset(reset), .direction(direction), .count3(count3),
        .snap_req(snap_req), .auto_en(auto_en), .tx_data(tx_data4), .tx_valid(tx_valid4),
        .tx_ready(tx_ready), .busy(busy4), .overrun(overrun4), .drop_cnt(drop_cnt4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_per   = 0;
        m_busy  = 0;
        m_pos   = 0;
        m_ovr   = 0;
        m_drops = 0;
    endtask

    task automatic model_step();
        bit tick;
        bit trig;
        tick  = auto_en && (m_per == PER8 - 1);
        m_per = auto_en ? (m_per + 1) % PER8 : 0;
        trig  = snap_req || tick;
        if (m_busy && tx_ready) begin
            m_pos++;
            if (m_pos == 6) m_busy = 0;
        end
        m_ovr = 0;
        if (trig) begin
            if (!m_busy) begin
                m_frame[0] = 8'hA4 | {7'd0, direction};
                for (int k = 1; k <= 4; k++) m_frame[k] = 8'(count3 >> (8 * (4 - k)));
                m_frame[5] = m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3] ^ m_frame[4];
                m_busy = 1;
                m_pos  = 0;
            end else begin
                m_ovr = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        snap_req = 1'b0;
        auto_en  = 1'b0;
        tx_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        total++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt: got %h expected 00", drop_cnt); else passed++;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAD};
        direction = 1'b1;
        count3    = 32'h1234_5678;
        tx_ready  = 1'b1;
        snap_req  = 1'b1;
        cycle();
        snap_req  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({tx_valid, tx_data} !== {1'b1, exp_b[k]})
                $display("FAIL single_byte%0d: got v=%b d=%h expected v=1 d=%h", k, tx_valid, tx_data, exp_b[k]);
            else passed++;
            cycle();
        end
        total++;
        if ({tx_valid, busy} !== 2'b00) $display("FAIL single_end: got v=%b busy=%b expected 0 0", tx_valid, busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        direction = 1'b0;
        count3    = 32'hDEAD_BEEF;
        for (int c = 0; c < 12; c++) begin
            snap_req = (c == 0);
            tx_ready = !(c >= 3 && c <= 5);
            if (c == 3) begin
                count3    = 32'h0000_0000;
                direction = 1'b1;
            end
            cycle();
            total++;
            if ({tx_valid, busy, overrun, drop_cnt} !== {m_busy, m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL bp_ctrl c=%0d: got %b %b %b %h expected %b %b %b %h", c, tx_valid, busy, overrun,
                         drop_cnt, m_busy, m_busy, m_ovr, 8'(m_drops));
            else passed++;
            if (m_busy) begin
                total++;
                if (tx_data !== m_frame[m_pos]) $display("FAIL bp_data c=%0d: got %h expected %h", c, tx_data, m_frame[m_pos]);
                else passed++;
            end
            if (c >= 3 && c <= 5) begin
                total++;
                if ({tx_valid, tx_data} !== {1'b1, 8'hAD})
                    $display("FAIL bp_hold c=%0d: got v=%b d=%h expected v=1 d=ad", c, tx_valid, tx_data);
                else passed++;
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_overrun();
        direction = 1'b1;
        count3    = 32'hCAFE_F00D;
        for (int c = 0; c < 10; c++) begin
            snap_req = (c == 0) || (c == 4);
            cycle();
            total++;
            if ({tx_valid, busy, overrun, drop_cnt} !== {m_busy, m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL ovr_ctrl c=%0d: got %b %b %b %h expected %b %b %b %h", c, tx_valid, busy, overrun,
                         drop_cnt, m_busy, m_busy, m_ovr, 8'(m_drops));
            else passed++;
            if (m_busy) begin
                total++;
                if (tx_data !== m_frame[m_pos]) $display("FAIL ovr_data c=%0d: got %h expected %h", c, tx_data, m_frame[m_pos]);
                else passed++;
            end
            if (c == 4) begin
                total++;
                if ({overrun, drop_cnt} !== {1'b1, 8'd1})
                    $display("FAIL ovr_pulse: got ovr=%b cnt=%0d expected ovr=1 cnt=1", overrun, drop_cnt);
                else passed++;
            end
            if (c == 5) begin
                total++;
                if (overrun !== 1'b0) $display("FAIL ovr_single: got %b expected 0", overrun);
                else passed++;
            end
        end
        snap_req = 1'b1;
        for (int c = 0; c < 400; c++) begin
            cycle();
            total++;
            if ({tx_valid, overrun, drop_cnt} !== {m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL sat_ctrl c=%0d: got %b %b %h expected %b %b %h", c, tx_valid, overrun, drop_cnt,
                         m_busy, m_ovr, 8'(m_drops));
            else passed++;
        end
        total++;
        if (drop_cnt !== 8'd255) $display("FAIL sat_value: got %0d expected 255", drop_cnt);
        else passed++;
        snap_req = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 14; c++) begin
            snap_req = (c == 0) || (c == 6);
            if (c == 0) begin
                count3    = 32'h0F1E_2D3C;
                direction = 1'b0;
            end
            if (c == 6) begin
                count3    = 32'h89AB_CDEF;
                direction = 1'b1;
            end
            cycle();
            total++;
            if ({tx_valid, busy, overrun, drop_cnt} !== {m_busy, m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL b2b_ctrl c=%0d: got %b %b %b %h expected %b %b %b %h", c, tx_valid, busy, overrun,
                         drop_cnt, m_busy, m_busy, m_ovr, 8'(m_drops));
            else passed++;
            if (m_busy) begin
                total++;
                if (tx_data !== m_frame[m_pos]) $display("FAIL b2b_data c=%0d: got %h expected %h", c, tx_data, m_frame[m_pos]);
                else passed++;
            end
            if (c == 6) begin
                total++;
                if ({tx_valid, tx_data} !== {1'b1, 8'hA5})
                    $display("FAIL b2b_header: got v=%b d=%h expected v=1 d=a5", tx_valid, tx_data);
                else passed++;
            end
            if (c == 7) begin
                total++;
                if (tx_data !== 8'h89) $display("FAIL b2b_snapshot: got %h expected 89", tx_data);
                else passed++;
            end
        end
        snap_req = 1'b0;
    endtask

    task automatic test_periodic8();
        int   starts;
        logic prev_valid;
        do_reset();
        auto_en    = 1'b1;
        starts     = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            cycle();
            if (tx_valid && !prev_valid) starts++;
            prev_valid = tx_valid;
            total++;
            if ({tx_valid, busy, overrun, drop_cnt} !== {m_busy, m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL per8_ctrl c=%0d: got %b %b %b %h expected %b %b %b %h", c, tx_valid, busy, overrun,
                         drop_cnt, m_busy, m_busy, m_ovr, 8'(m_drops));
            else passed++;
            if (m_busy) begin
                total++;
                if (tx_data !== m_frame[m_pos]) $display("FAIL per8_data c=%0d: got %h expected %h", c, tx_data, m_frame[m_pos]);
                else passed++;
            end
        end
        total++;
        if ({starts, drop_cnt} !== {32'd8, 8'd0})
            $display("FAIL per8_summary: got starts=%0d drops=%0d expected starts=8 drops=0", starts, drop_cnt);
        else passed++;
        auto_en = 1'b0;
    endtask

    task automatic test_periodic4();
        do_reset();
        auto_en = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            cycle();
            total++;
            if ({overrun4, drop_cnt4} !== {(n % 8) == 0, 8'(n / 8)})
                $display("FAIL per4 n=%0d: got ovr=%b cnt=%0d expected ovr=%b cnt=%0d", n, overrun4, drop_cnt4,
                         (n % 8) == 0, n / 8);
            else passed++;
        end
        auto_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            snap_req  = ($urandom_range(0, 7) == 0);
            tx_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            count3    = $urandom;
            direction = 1'($urandom_range(0, 1));
            cycle();
            total++;
            if ({tx_valid, busy, overrun, drop_cnt} !== {m_busy, m_busy, m_ovr, 8'(m_drops)})
                $display("FAIL rand_ctrl c=%0d: got %b %b %b %h expected %b %b %b %h", c, tx_valid, busy, overrun,
                         drop_cnt, m_busy, m_busy, m_ovr, 8'(m_drops));
            else passed++;
            if (m_busy) begin
                total++;
                if (tx_data !== m_frame[m_pos]) $display("FAIL rand_data c=%0d: got %h expected %h", c, tx_data, m_frame[m_pos]);
                else passed++;
            end
        end
        snap_req = 1'b0;
        auto_en  = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        count3    = 32'h5566_7788;
        direction = 1'b0;
        for (int c = 0; c < 3; c++) begin
            snap_req = (c < 2);
            cycle();
        end
        snap_req = 1'b0;
        total++;
        if ({tx_valid, busy, drop_cnt, tx_data} !== {1'b1, 1'b1, 8'd1, 8'h66})
            $display("FAIL mid_pre: got v=%b b=%b cnt=%0d d=%h expected v=1 b=1 cnt=1 d=66", tx_valid, busy, drop_cnt, tx_data);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({tx_valid, busy, drop_cnt} !== {1'b0, 1'b0, 8'd0})
            $display("FAIL mid_async: got v=%b b=%b cnt=%0d expected 0 0 0", tx_valid, busy, drop_cnt);
        else passed++;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            total++;
            if ({tx_valid, busy} !== 2'b00) $display("FAIL mid_quiet c=%0d: got v=%b b=%b expected 0 0", c, tx_valid, busy);
            else passed++;
        end
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        total++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hA4})
            $display("FAIL mid_restart: got v=%b d=%h expected v=1 d=a4", tx_valid, tx_data);
        else passed++;
        repeat (8) cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_periodic8();
        test_periodic4();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
